// File: rtl/cordic_pkg.sv
// cordic_pkg
//   Shared definitions for the CORDIC angle path: the quarter-turn constant,
//   the quadrant and mode encodings, and the sweep FSM states.
//   The CORDIC core also uses the quadrant enum to unfold its result.
package cordic_pkg;

  // Quarter turn (90 degrees) expressed in 2^-frac_w degree units.
  function automatic int unsigned quarter_of(input int unsigned frac_w);
    return 32'd90 << frac_w;
  endfunction

  typedef enum logic [1:0] {
    Q0 = 2'd0,
    Q1 = 2'd1,
    Q2 = 2'd2,
    Q3 = 2'd3
  } quad_e;

  typedef enum logic {
    MODE_CONT    = 1'b0,
    MODE_ONESHOT = 1'b1
  } mode_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } sweep_st_e;

endpackage

// File: rtl/cordic_angle_sweep_step_dither.sv
// step_dither
//   Chooses the angle increment for each advance. Normally the main step is
//   used; once every alt_period+1 advances the alternate step replaces it.
//   Ports:
//     clk, rst    clock, synchronous active-high reset
//     en_adv      an advance happens on this edge
//     clr         restart the dither cadence (one-shot start)
//     step_main   normal increment
//     step_alt    dither increment
//     alt_period  dither period, 0 disables the alternate step
//     step        increment to apply on the current advance
module step_dither
  import cordic_pkg::*;
#(
  parameter int STEP_W = 8,
  parameter int PER_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en_adv,
  input  logic              clr,
  input  logic [STEP_W-1:0] step_main,
  input  logic [STEP_W-1:0] step_alt,
  input  logic [PER_W-1:0]  alt_period,
  output logic [STEP_W-1:0] step
);

  logic [PER_W-1:0] cnt_r;
  logic             alt_on_s;
  logic             alt_hit_s;

  // Select the alternate step when the counter reaches the period.
  always_comb begin
    alt_on_s  = (alt_period != {PER_W{1'b0}});
    alt_hit_s = alt_on_s && (cnt_r == alt_period);
    if (alt_hit_s) begin
      step = step_alt;
    end else begin
      step = step_main;
    end
  end

  // Dither counter: restarts after an alternate step, parked at 0 when disabled.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= {PER_W{1'b0}};
    end else if (clr) begin
      cnt_r <= {PER_W{1'b0}};
    end else if (en_adv) begin
      if (alt_hit_s || !alt_on_s) begin
        cnt_r <= {PER_W{1'b0}};
      end else begin
        cnt_r <= cnt_r + {{(PER_W-1){1'b0}}, 1'b1};
      end
    end else begin
      cnt_r <= cnt_r;
    end
  end

endmodule

// File: rtl/cordic_angle_sweep.sv
// cordic_angle_sweep
//   Sweeps a full turn as a first-quadrant magnitude plus quadrant code,
//   ascending in quadrants 0/2 and descending in 1/3, clamped exactly at the
//   boundaries. Continuous or one-shot operation.
//   Ports:
//     clk, rst                  clock, synchronous active-high reset
//     en                        advance enable
//     mode                      0 continuous, 1 one-shot
//     start                     one-shot trigger pulse
//     step_main/step_alt        increments (LSB = 2^-FRAC_W degree)
//     alt_period                dither period, 0 disables
//     ang, qrt                  angle magnitude and quadrant
//     valid                     ang/qrt were advanced on the last edge
//     busy                      one-shot sweep in progress
//     wrap                      quadrant just went 3 -> 0
module cordic_angle_sweep
  import cordic_pkg::*;
#(
  parameter int ANG_W  = 16,
  parameter int FRAC_W = 8,
  parameter int STEP_W = 8,
  parameter int PER_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              mode,
  input  logic              start,
  input  logic [STEP_W-1:0] step_main,
  input  logic [STEP_W-1:0] step_alt,
  input  logic [PER_W-1:0]  alt_period,
  output logic [ANG_W-1:0]  ang,
  output logic [1:0]        qrt,
  output logic              valid,
  output logic              busy,
  output logic              wrap
);

  localparam int unsigned    QUARTER   = quarter_of(FRAC_W);
  localparam logic [ANG_W:0] QUARTER_X = (ANG_W+1)'(QUARTER);

  sweep_st_e         state_r;
  logic [ANG_W-1:0]  ang_r;
  logic [1:0]        qrt_r;
  logic              valid_r;
  logic              wrap_r;

  logic [STEP_W-1:0] step_s;
  logic              adv_s;
  logic              clr_s;
  logic [ANG_W:0]    ang_x_s;
  logic [ANG_W:0]    step_x_s;
  logic [ANG_W:0]    sum_s;
  logic [ANG_W:0]    diff_s;
  logic [ANG_W-1:0]  ang_nxt_s;
  logic              cross_s;
  logic              last_s;

  // Advance and one-shot launch qualifiers; the two never coincide.
  always_comb begin
    adv_s = en && ((mode == MODE_CONT) || (state_r == ST_RUN));
    clr_s = start && (mode == MODE_ONESHOT) && (state_r == ST_IDLE);
  end

  step_dither #(
    .STEP_W (STEP_W),
    .PER_W  (PER_W)
  ) u_dither (
    .clk        (clk),
    .rst        (rst),
    .en_adv     (adv_s),
    .clr        (clr_s),
    .step_main  (step_main),
    .step_alt   (step_alt),
    .alt_period (alt_period),
    .step       (step_s)
  );

  // Fold/clamp datapath, one bit wider so the sum never overflows.
  always_comb begin
    ang_x_s  = {1'b0, ang_r};
    step_x_s = (ANG_W+1)'(step_s);
    sum_s    = ang_x_s + step_x_s;
    diff_s   = ang_x_s - step_x_s;
    if (qrt_r[0] == 1'b0) begin
      if (sum_s >= QUARTER_X) begin
        ang_nxt_s = QUARTER_X[ANG_W-1:0];
        cross_s   = 1'b1;
      end else begin
        ang_nxt_s = sum_s[ANG_W-1:0];
        cross_s   = 1'b0;
      end
    end else begin
      // Reaching exactly 0 also ends the quadrant, so step 0 at 0 still moves on.
      if (ang_x_s <= step_x_s) begin
        ang_nxt_s = {ANG_W{1'b0}};
        cross_s   = 1'b1;
      end else begin
        ang_nxt_s = diff_s[ANG_W-1:0];
        cross_s   = 1'b0;
      end
    end
    last_s = cross_s && (qrt_r == Q3);
  end

  // Angle, quadrant, status pulses and one-shot FSM.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      ang_r   <= {ANG_W{1'b0}};
      qrt_r   <= 2'd0;
      valid_r <= 1'b0;
      wrap_r  <= 1'b0;
    end else begin
      valid_r <= adv_s;
      if (adv_s) begin
        ang_r  <= ang_nxt_s;
        qrt_r  <= cross_s ? (qrt_r + 2'd1) : qrt_r;
        wrap_r <= last_s;
      end else if (clr_s) begin
        ang_r  <= {ANG_W{1'b0}};
        qrt_r  <= 2'd0;
        wrap_r <= 1'b0;
      end else begin
        ang_r  <= ang_r;
        qrt_r  <= qrt_r;
        wrap_r <= 1'b0;
      end
      case (state_r)
        ST_IDLE: begin
          if (clr_s) begin
            state_r <= ST_RUN;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_RUN: begin
          // Leaving one-shot mode abandons the sweep bookkeeping only.
          if ((mode == MODE_CONT) || (adv_s && last_s)) begin
            state_r <= ST_IDLE;
          end else begin
            state_r <= ST_RUN;
          end
        end
        default: state_r <= ST_IDLE;
      endcase
    end
  end

  assign ang   = ang_r;
  assign qrt   = qrt_r;
  assign valid = valid_r;
  assign wrap  = wrap_r;
  assign busy  = (state_r == ST_RUN);

endmodule

// File: tb/tb_cordic_angle_sweep.sv
module tb_cordic_angle_sweep;

  logic        clk;
  logic        rst;
  logic        en;
  logic        mode;
  logic        start;
  logic [7:0]  step_main;
  logic [7:0]  step_alt;
  logic [7:0]  alt_period;
  logic [15:0] ang;
  logic [1:0]  qrt;
  logic        valid;
  logic        busy;
  logic        wrap;

  int n_checks;
  int n_fail;
  int wrap_seen;

  cordic_angle_sweep dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .mode       (mode),
    .start      (start),
    .step_main  (step_main),
    .step_alt   (step_alt),
    .alt_period (alt_period),
    .ang        (ang),
    .qrt        (qrt),
    .valid      (valid),
    .busy       (busy),
    .wrap       (wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (obs !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock edge, then settle before sampling or driving.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    wrap_seen = 0;
    rst = 1'b1; en = 1'b0; mode = 1'b0; start = 1'b0;
    step_main = 8'd0; step_alt = 8'd0; alt_period = 8'd0;
    tick(2);
    rst = 1'b0;

    // Reset state
    chk("rst_ang", ang, 0);
    chk("rst_qrt", qrt, 0);
    chk("rst_valid", valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_wrap", wrap, 0);
    chk("rst_cnt", dut.u_dither.cnt_r, 0);

    // Dither cadence: 6 x 15 + 2
    step_main = 8'd15; step_alt = 8'd2; alt_period = 8'd6; en = 1'b1;
    tick(7);
    chk("dith_ang", ang, 92);
    chk("dith_cnt", dut.u_dither.cnt_r, 0);
    chk("dith_qrt", qrt, 0);
    chk("dith_valid", valid, 1);
    tick(2);
    chk("dith_ang2", ang, 122);

    // Enable gating mid-quadrant
    en = 1'b0;
    tick(10);
    chk("gate_ang", ang, 122);
    chk("gate_cnt", dut.u_dither.cnt_r, 2);
    chk("gate_qrt", qrt, 0);
    chk("gate_valid", valid, 0);
    en = 1'b1;
    tick(1);
    chk("resume_ang", ang, 137);
    chk("resume_cnt", dut.u_dither.cnt_r, 3);
    chk("resume_valid", valid, 1);

    // Full turn, continuous
    en = 1'b0; alt_period = 8'd0; step_main = 8'd100;
    do_reset();
    en = 1'b1;
    for (int i = 1; i <= 924; i++) begin
      tick(1);
      if (wrap) wrap_seen = wrap_seen + 1;
      if (i == 230) begin chk("ft230_ang", ang, 23000); chk("ft230_qrt", qrt, 0); end
      if (i == 231) begin chk("ft231_ang", ang, 23040); chk("ft231_qrt", qrt, 1); end
      if (i == 461) begin chk("ft461_ang", ang, 40); chk("ft461_qrt", qrt, 1); end
      if (i == 462) begin chk("ft462_ang", ang, 0); chk("ft462_qrt", qrt, 2); end
      if (i == 923) begin chk("ft923_qrt", qrt, 3); chk("ft923_wrap", wrap, 0); end
      if (i == 924) begin
        chk("ft924_qrt", qrt, 0); chk("ft924_ang", ang, 0); chk("ft924_wrap", wrap, 1);
      end
    end
    chk("ft_wrap_count", wrap_seen, 1);
    tick(1);
    chk("ft925_ang", ang, 100);
    chk("ft925_wrap", wrap, 0);
    chk("ft_busy_cont", busy, 0);

    // One-shot sweep
    en = 1'b0;
    do_reset();
    mode = 1'b1; en = 1'b1;
    tick(1);
    chk("os_idle_valid", valid, 0);
    chk("os_idle_ang", ang, 0);
    en = 1'b0; start = 1'b1;
    tick(1);
    start = 1'b0;
    chk("os_busy", busy, 1);
    chk("os_start_valid", valid, 0);
    chk("os_start_ang", ang, 0);
    en = 1'b1;
    for (int i = 1; i <= 924; i++) begin
      if (i == 101) start = 1'b1;
      tick(1);
      start = 1'b0;
      if (i == 101) begin chk("os_ign_ang", ang, 10100); chk("os_ign_busy", busy, 1); end
      if (i == 923) chk("os923_busy", busy, 1);
      if (i == 924) begin
        chk("os_end_busy", busy, 0); chk("os_end_ang", ang, 0);
        chk("os_end_qrt", qrt, 0); chk("os_end_wrap", wrap, 1);
      end
    end
    tick(3);
    chk("os_after_valid", valid, 0);
    chk("os_after_ang", ang, 0);
    chk("os_after_wrap", wrap, 0);

    // start and rst together: rst wins
    en = 1'b0; rst = 1'b1; start = 1'b1;
    tick(1);
    rst = 1'b0; start = 1'b0;
    chk("rst_start_busy", busy, 0);

    // Step 0 holds; exact landing on QUARTER still changes quadrant
    mode = 1'b0; en = 1'b1; step_main = 8'd100;
    tick(5);
    chk("s0_pre_ang", ang, 500);
    step_main = 8'd0;
    tick(3);
    chk("s0_hold_ang", ang, 500);
    chk("s0_hold_valid", valid, 1);
    step_main = 8'd250;
    tick(90);
    chk("s0_23000", ang, 23000);
    step_main = 8'd0;
    tick(1);
    chk("s0_hold2_ang", ang, 23000);
    chk("s0_hold2_qrt", qrt, 0);
    step_main = 8'd40;
    tick(1);
    chk("edge_ang", ang, 23040);
    chk("edge_qrt", qrt, 1);
    step_main = 8'd0;
    tick(1);
    chk("s0_desc_ang", ang, 23040);
    chk("s0_desc_qrt", qrt, 1);

    // Reset mid-sweep at qrt 2, ang 1234
    en = 1'b0;
    do_reset();
    en = 1'b1; step_main = 8'd100;
    tick(462);
    step_main = 8'd200;
    tick(6);
    step_main = 8'd34;
    tick(1);
    chk("mid_ang", ang, 1234);
    chk("mid_qrt", qrt, 2);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    en = 1'b0;
    chk("mrst_ang", ang, 0);
    chk("mrst_qrt", qrt, 0);
    chk("mrst_valid", valid, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_wrap", wrap, 0);
    chk("mrst_cnt", dut.u_dither.cnt_r, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cordic_angle_sweep.md
# cordic_angle_sweep

Parametrised angle/quadrant stimulus generator for the CORDIC core. It produces a fixed-point first-quadrant angle magnitude `ang` plus a quadrant code `qrt`, sweeping a full turn with a triangle fold: ascending in quadrants 0 and 2, descending in 1 and 3. The step size is programmable with periodic alternate-step dithering. It supports continuous or one-shot operation and drives `ang`/`qrt` straight into the CORDIC angle inputs.

## Interface
- `ANG_W`, 16, width of `ang`.
- `FRAC_W`, 8, fractional bits of `ang` in degrees; `QUARTER` = 90 << `FRAC_W` (23040 at default); `QUARTER` < 2^`ANG_W` is required.
- `STEP_W`, 8, width of the step inputs.
- `PER_W`, 8, width of `alt_period`.
- `clk`  in  1  single clock; all logic on its rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `en`  in  1  advance enable; when low all state holds.
- `mode`  in  1  0 = continuous, 1 = one-shot.
- `start`  in  1  one-shot trigger, single-cycle pulse; ignored in continuous mode and while `busy`.
- `step_main`  in  `STEP_W`  normal increment (LSB = 2^-`FRAC_W` deg).
- `step_alt`  in  `STEP_W`  increment used once every `alt_period`+1 advances.
- `alt_period`  in  `PER_W`  dither period; 0 disables alternate steps.
- `ang`  out  `ANG_W`  angle magnitude, range 0..`QUARTER`.
- `qrt`  out  2  quadrant 0..3.
- `valid`  out  1  high in each cycle where `ang`/`qrt` hold a freshly advanced value.
- `busy`  out  1  one-shot sweep in progress; always 0 in continuous mode.
- `wrap`  out  1  one-cycle pulse when `qrt` goes 3 -> 0.

## Operation
- An advance occurs on an edge where `en`=1 and (`mode`=0, or `busy`=1 in one-shot mode).
- Dither counter `cnt` (`PER_W` bits):
  - If `alt_period`≠0 and `cnt`==`alt_period`: step = `step_alt` and `cnt` <= 0.
  - Otherwise step = `step_main` and `cnt` <= `cnt`+1 when `alt_period`≠0; `cnt` stays 0 when `alt_period`==0.
- Arithmetic is done at `ANG_W`+1 bits with no overflow.
- Ascending quadrants (0, 2):
  - Compute nxt = `ang`+step.
  - If nxt ≥ `QUARTER`: `ang` <= `QUARTER`, `qrt` <= `qrt`+1.
  - Otherwise `ang` <= nxt.
- Descending quadrants (1, 3):
  - If `ang` ≤ step: `ang` <= 0, `qrt` <= `qrt`+1 (mod 4).
  - Otherwise `ang` <= `ang`−step.
- Boundaries are clamped exactly; the overshoot is discarded, not carried into the next quadrant.
- Step 0 holds `ang`. A quadrant still advances if `ang` already sits on the boundary (`QUARTER` when ascending, 0 when descending).
- Step inputs are sampled live on every advance; changing them mid-sweep is legal.
- One-shot states:
  - IDLE (`busy`=0): `start`=1 -> RUN, clears `cnt`, `ang`=0, `qrt`=0.
  - RUN (`busy`=1): advances per rule. The advance that takes `qrt` 3 -> 0 pulses `wrap` and returns to IDLE.
- Changing `mode` while `busy`:
  - A switch to continuous clears `busy` and sweeping continues.
  - A switch to one-shot leaves the block in IDLE.
- `start` and `rst` in the same cycle: `rst` wins.

## Timing
- Reset values: `ang`=0, `qrt`=0, `valid`=0, `busy`=0, `wrap`=0, `cnt`=0.
- Latency is 1 cycle: an advance on edge N gives new `ang`/`qrt` and `valid`=1 after edge N; `valid` is 0 after any non-advancing edge.
- `wrap` is asserted in the same cycle as `qrt`=0 following the 3 -> 0 transition.
- `busy` rises the cycle after `start` is sampled. The first advance needs `en` on a later edge; `start` itself does not advance.
- Reset mid-sweep returns every output to its reset value on the next edge, independent of `en`.
- All outputs are registered; there is no combinational input-to-output path.

## Structure
- Shared package `cordic_pkg`:
  - `QUARTER` function of `FRAC_W`.
  - Quadrant enum `Q0..Q3`.
  - Mode enum `MODE_CONT`/`MODE_ONESHOT`.
  - These are reused by the CORDIC core for quadrant unfolding.
- Sub-module `step_dither`: owns `cnt` and selects the step (inputs `en_adv`, `clr`, `step_main`, `step_alt`, `alt_period`; output `step`).
- Top level holds the fold/clamp datapath, quadrant counter and one-shot FSM.

## Test plan
- Dither cadence: continuous mode, `step_main`=15, `step_alt`=2, `alt_period`=6, `en`=1 -> after 7 advances `ang`=92 (6×15+2), `cnt`=0, `qrt`=0.
- Full turn: `step_main`=100, `alt_period`=0.
  - At advance 231: `ang` clamps to 23040, `qrt`=1.
  - At advance 462: `ang`=0, `qrt`=2.
  - At advance 924: `qrt`=0, `wrap`=1 for exactly one cycle.
- One-shot: `mode`=1, same steps, pulse `start` -> `busy`=1 next cycle; after 924 advances `busy`=0, `ang`=0, `qrt`=0; further `en` gives no change and `valid`=0. A second `start` while `busy` is ignored.
- Enable gating: drop `en` for 10 cycles mid-quadrant -> `ang`, `qrt` and `cnt` frozen, `valid`=0; resume continues from the identical value.
- Step 0: hold `ang`=500 with `step_main`=0 -> no change. Step 0 at `ang`=`QUARTER` in `qrt`=0 -> `qrt`=1 on the next advance.
- Reset mid-sweep: assert `rst` at `qrt`=2, `ang`=1234 with `en`=1 -> next cycle all outputs are 0.
